// File: rtl/dec_pkg.sv
// Shared decode-stage definitions: next-PC select encodings, instruction field
// positions and the opcode/function constants used by the MIPS decoder.
package dec_pkg;

    typedef enum logic [1:0] {
        BR_BRANCH = 2'b00,
        BR_JUMP   = 2'b01,
        BR_REG    = 2'b10,
        BR_SEQ    = 2'b11
    } br_sel_t;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned JT_MSB  = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/dec_lfsr.sv
// Galois LFSR used as the random-immediate source; right-shifting, seedable,
// and held while the decode stage is stalled. Never enters the all-zero state.
module dec_lfsr #(
    parameter int unsigned        LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_step;
    logic [LFSR_W-1:0] w_next;

    assign w_step = (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : '0);

    // A zero seed would lock the register up, so it is replaced by 1.
    always_comb begin
        w_next = r_state;
        if (load)
            w_next = (seed == '0) ? LFSR_W'(1) : seed;
        else if (en)
            w_next = w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LFSR_SEED;
        else
            r_state <= w_next;
    end

    assign value = r_state;

endmodule

// File: rtl/dec_pipe.sv
// MIPS decode stage: IF/ID register, register file with write-first bypass,
// forwarding muxes, immediate extension / LFSR immediate, next-PC targets, compares.
module dec_pipe
    import dec_pkg::*;
#(
    parameter int unsigned       XLEN      = 32,
    parameter int unsigned       NREG      = 32,
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0001,
    parameter bit                RF_BYPASS = 1'b1,
    localparam int unsigned      RA        = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inst_F,
    input  logic [XLEN-1:0]   PC_plus_4_F,
    input  logic              valid_F,
    input  logic              stall_D,
    input  logic              flush_D,
    input  logic              rw,
    input  logic [RA-1:0]     write_add,
    input  logic [XLEN-1:0]   data_in,
    input  logic [XLEN-1:0]   alu_out_M,
    input  logic              forward_a_D,
    input  logic              forward_b_D,
    input  logic              unsignedD,
    input  logic              randomD,
    input  logic              usezeroD,
    input  logic [1:0]        branch_src,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              valid_D,
    output logic [5:0]        opcode_D,
    output logic [5:0]        function_D,
    output logic [RA-1:0]     rs_D,
    output logic [RA-1:0]     rt_D,
    output logic [RA-1:0]     rd_D,
    output logic [XLEN-1:0]   src_a_D,
    output logic [XLEN-1:0]   src_b_D,
    output logic [XLEN-1:0]   sign_imm_D,
    output logic [XLEN-1:0]   next_br_D,
    output logic              a_eq_b_D,
    output logic              a_eq_z_D,
    output logic              a_gt_z_D,
    output logic              a_lt_z_D
);

    logic [31:0]       r_inst_D;
    logic [XLEN-1:0]   r_pc4_D;
    logic              r_valid_D;
    logic [XLEN-1:0]   r_rf [NREG];

    logic [RA-1:0]     w_rs;
    logic [RA-1:0]     w_rt;
    logic [XLEN-1:0]   w_rf_a;
    logic [XLEN-1:0]   w_rf_b;
    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_ext;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_next_br;
    logic [LFSR_W-1:0] w_lfsr;

    // Flush wins over stall so a squashed slot never survives a held pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst_D  <= '0;
            r_pc4_D   <= '0;
            r_valid_D <= 1'b0;
        end else if (flush_D) begin
            r_inst_D  <= '0;
            r_pc4_D   <= '0;
            r_valid_D <= 1'b0;
        end else if (!stall_D) begin
            r_inst_D  <= inst_F;
            r_pc4_D   <= PC_plus_4_F;
            r_valid_D <= valid_F;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_rf[i] <= '0;
        end else if (rw && (write_add != '0)) begin
            r_rf[write_add] <= data_in;
        end
    end

    dec_lfsr #(
        .LFSR_W   (LFSR_W),
        .LFSR_TAPS(LFSR_TAPS),
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(reset),
        .en   (!stall_D),
        .load (seed_we),
        .seed (seed_in),
        .value(w_lfsr)
    );

    assign w_rs = RA'(r_inst_D[RS_MSB:RS_LSB]);
    assign w_rt = RA'(r_inst_D[RT_MSB:RT_LSB]);

    always_comb begin
        w_rf_a = r_rf[w_rs];
        w_rf_b = r_rf[w_rt];
        if (RF_BYPASS && rw && (w_rs == write_add))
            w_rf_a = data_in;
        if (RF_BYPASS && rw && (w_rt == write_add))
            w_rf_b = data_in;
        if (w_rs == '0)
            w_rf_a = '0;
        if (w_rt == '0)
            w_rf_b = '0;
    end

    assign w_src_a = usezeroD ? '0 : (forward_a_D ? alu_out_M : w_rf_a);
    assign w_src_b = forward_b_D ? alu_out_M : w_rf_b;

    assign w_ext = unsignedD ? XLEN'(r_inst_D[IMM_MSB:0])
                             : XLEN'($signed(r_inst_D[IMM_MSB:0]));
    assign w_imm = randomD ? XLEN'(w_lfsr) : w_ext;

    always_comb begin
        w_next_br = r_pc4_D;
        case (br_sel_t'(branch_src))
            BR_BRANCH: w_next_br = r_pc4_D + {w_imm[XLEN-3:0], 2'b00};
            BR_JUMP:   w_next_br = {r_pc4_D[XLEN-1:28], r_inst_D[JT_MSB:0], 2'b00};
            BR_REG:    w_next_br = w_src_a;
            BR_SEQ:    w_next_br = r_pc4_D;
        endcase
    end

    assign valid_D    = r_valid_D;
    assign opcode_D   = r_inst_D[OP_MSB:OP_LSB];
    assign function_D = r_inst_D[FN_MSB:0];
    assign rs_D       = w_rs;
    assign rt_D       = w_rt;
    assign rd_D       = RA'(r_inst_D[RD_MSB:RD_LSB]);
    assign src_a_D    = w_src_a;
    assign src_b_D    = w_src_b;
    assign sign_imm_D = w_imm;
    assign next_br_D  = w_next_br;

    assign a_eq_b_D = (w_src_a == w_src_b);
    assign a_eq_z_D = (w_src_a == '0);
    assign a_lt_z_D = w_src_a[XLEN-1];
    assign a_gt_z_D = !w_src_a[XLEN-1] && (w_src_a != '0);

endmodule
